sp_ram_ctrl: RTL and testbench

- Initiator-side front-end for a single-port SRAM macro/model (A/DI/BW/CE/RDWEN/DO port, 1-cycle registered read, byte-wide write enables).
- Converts a valid/ready request stream into SRAM port cycles.
- Collects the read data into a small response FIFO, so requesters see a backpressurable valid/ready response stream.
- Sits between a cache/buffer client and the SRAM instance.

---
 rtl/mem_lib_pkg.sv | 24 ++
 rtl/sp_ram_ctrl_rsp_fifo.sv | 78 +++++++
 rtl/sp_ram_ctrl.sv | 98 +++++++++
 tb/tb_sp_ram_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lib_pkg.sv
// Shared constants and elaboration helpers for the SRAM front-end blocks.
package mem_lib_pkg;

  localparam logic RDWEN_WRITE = 1'b1;
  localparam logic RDWEN_READ  = 1'b0;

  // Returns 1 for a zero column width so port declarations stay legal until the width check
  // stops elaboration.
  function automatic int unsigned num_col(input int unsigned data_width,
                                          input int unsigned col_width);
    return (col_width == 0) ? 1 : data_width / col_width;
  endfunction

  function automatic bit widths_ok(input int unsigned data_width,
                                   input int unsigned col_width);
    return (col_width != 0) && (data_width != 0) && ((data_width % col_width) == 0);
  endfunction

  // Index width that stays at least one bit for single-entry structures.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sp_ram_ctrl_rsp_fifo.sv
// Response FIFO for sp_ram_ctrl: DEPTH entries, any depth >= 1, synchronous active-high reset.
module sp_ram_ctrl_rsp_fifo
  import mem_lib_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH = 1,
  parameter int unsigned  DEPTH      = 3,
  localparam int unsigned PTR_W      = idx_width(DEPTH),
  localparam int unsigned CNT_W      = idx_width(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [CNT_W-1:0]      count,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full;
  logic                  pop_en;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign pop_en = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop_en) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop_en) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop_en) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  // Slot reservation upstream means a push can never land on a full FIFO.
  assert property (@(posedge CLK) disable iff (RST) !(push && full))
    else $error("sp_ram_ctrl_rsp_fifo overflow");

endmodule

// File: rtl/sp_ram_ctrl.sv
// Single-port SRAM front-end: valid/ready requests drive the SRAM port directly, read data
// returns through a reserved-slot response FIFO.
module sp_ram_ctrl
  import mem_lib_pkg::*;
#(
  parameter int unsigned  ADDR_WIDTH = 1,
  parameter int unsigned  COL_WIDTH  = 1,
  parameter int unsigned  DATA_WIDTH = 1,
  parameter int unsigned  RSP_DEPTH  = 3,
  localparam int unsigned NUM_COL    = num_col(DATA_WIDTH, COL_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  // Request stream
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_COL-1:0]    req_be,
  // Response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  // SRAM port
  output logic [ADDR_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] DI,
  output logic [NUM_COL-1:0]    BW,
  output logic                  CE,
  output logic                  RDWEN,
  input  logic [DATA_WIDTH-1:0] DO
);

  localparam int unsigned CNT_W = idx_width(RSP_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  if (!widths_ok(DATA_WIDTH, COL_WIDTH)) begin : g_bad_width
    $fatal(1, "sp_ram_ctrl: DATA_WIDTH must be a non-zero multiple of COL_WIDTH");
  end
  if (RSP_DEPTH < 1) begin : g_bad_depth
    $fatal(1, "sp_ram_ctrl: RSP_DEPTH must be at least 1");
  end

  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_count;
  logic [OCC_W-1:0] occ;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             req_fire;
  logic             rd_fire;

  // Occupancy counts the read already sitting in the SRAM pipeline, so a slot is reserved
  // at accept time and rsp_ready never reaches req_ready combinationally.
  assign occ = OCC_W'(fifo_count) + OCC_W'(inflight_q);

  always_comb begin
    req_ready = !RST && (req_we || (occ < OCC_W'(RSP_DEPTH)));
  end

  assign req_fire = req_valid && req_ready;
  assign rd_fire  = req_fire && !req_we;

  always_comb begin
    CE    = req_fire;
    A     = req_addr;
    DI    = req_wdata;
    RDWEN = req_we ? RDWEN_WRITE : RDWEN_READ;
    BW    = req_we ? req_be : '0;
  end

  assign inflight_d = rd_fire;

  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign rsp_valid = !fifo_empty;
  assign fifo_pop  = rsp_valid && rsp_ready;

  sp_ram_ctrl_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH)
  ) u_rsp_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (inflight_q),
    .wdata (DO),
    .pop   (fifo_pop),
    .rdata (rsp_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Bench for sp_ram_ctrl: depth-3 and depth-1 instances share one request stream, each with its
// own SRAM model and a scoreboard of expected responses.
module tb_sp_ram_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned NC = 4;

  logic          CLK;
  logic          RST;
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [NC-1:0] req_be;
  logic          rsp_ready;

  logic          req_ready_w [2];
  logic          rsp_valid_w [2];
  logic [DW-1:0] rdata_w     [2];
  logic [AW-1:0] a_w         [2];
  logic [DW-1:0] di_w        [2];
  logic [NC-1:0] bw_w        [2];
  logic          ce_w        [2];
  logic          rdwen_w     [2];
  logic [DW-1:0] do_w        [2];

  int n_vec;
  int n_err;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  sp_ram_ctrl #(
    .ADDR_WIDTH (AW), .COL_WIDTH (CW), .DATA_WIDTH (DW), .RSP_DEPTH (3)
  ) dut (
    .CLK (CLK), .RST (RST),
    .req_valid (req_valid), .req_ready (req_ready_w[0]), .req_we (req_we),
    .req_addr (req_addr), .req_wdata (req_wdata), .req_be (req_be),
    .rsp_valid (rsp_valid_w[0]), .rsp_ready (rsp_ready), .rsp_rdata (rdata_w[0]),
    .A (a_w[0]), .DI (di_w[0]), .BW (bw_w[0]), .CE (ce_w[0]), .RDWEN (rdwen_w[0]),
    .DO (do_w[0])
  );

  sp_ram_ctrl #(
    .ADDR_WIDTH (AW), .COL_WIDTH (CW), .DATA_WIDTH (DW), .RSP_DEPTH (1)
  ) dut1 (
    .CLK (CLK), .RST (RST),
    .req_valid (req_valid), .req_ready (req_ready_w[1]), .req_we (req_we),
    .req_addr (req_addr), .req_wdata (req_wdata), .req_be (req_be),
    .rsp_valid (rsp_valid_w[1]), .rsp_ready (rsp_ready), .rsp_rdata (rdata_w[1]),
    .A (a_w[1]), .DI (di_w[1]), .BW (bw_w[1]), .CE (ce_w[1]), .RDWEN (rdwen_w[1]),
    .DO (do_w[1])
  );

  // SRAM macro models: byte-masked write commit and registered read at the clock edge.
  logic [DW-1:0] sram [2][16];
  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (ce_w[k]) begin
        if (rdwen_w[k]) begin
          for (int b = 0; b < NC; b++) begin
            if (bw_w[k][b]) sram[k][a_w[k]][b*CW +: CW] <= di_w[k][b*CW +: CW];
          end
        end else begin
          do_w[k] <= sram[k][a_w[k]];
        end
      end
    end
  end

  // Reference: memory image plus an ordered list of pending reads, each visible two cycles
  // after acceptance; a read may be taken while fewer than depth reads are still unreturned.
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic [DW-1:0] ref_mem [2][16];
  exp_t          sbq     [2][$];
  logic          mon_en;
  int            cyc;
  int            dep;
  logic          exp_val;
  logic          exp_rdy;

  always @(negedge CLK) begin
    if (mon_en) begin
      cyc = cyc + 1;
      for (int k = 0; k < 2; k++) begin
        dep     = (k == 0) ? 3 : 1;
        exp_val = (sbq[k].size() != 0) && (sbq[k][0].due <= cyc);
        exp_rdy = !RST && (req_we || (sbq[k].size() < dep));
        n_vec++;
        if (rsp_valid_w[k] !== exp_val) begin
          n_err++;
          $display("FAIL rsp_valid dut%0d cyc %0d: got %b want %b", k, cyc, rsp_valid_w[k],
                   exp_val);
        end
        if (exp_val) begin
          n_vec++;
          if (rdata_w[k] !== sbq[k][0].data) begin
            n_err++;
            $display("FAIL rsp_rdata dut%0d cyc %0d: got %h want %h", k, cyc, rdata_w[k],
                     sbq[k][0].data);
          end
        end
        n_vec++;
        if (req_ready_w[k] !== exp_rdy) begin
          n_err++;
          $display("FAIL req_ready dut%0d cyc %0d: got %b want %b", k, cyc, req_ready_w[k],
                   exp_rdy);
        end
        n_vec++;
        if (ce_w[k] !== (req_valid && exp_rdy)) begin
          n_err++;
          $display("FAIL CE dut%0d cyc %0d: got %b want %b", k, cyc, ce_w[k],
                   req_valid && exp_rdy);
        end
        n_vec++;
        if ((a_w[k] !== req_addr) || (di_w[k] !== req_wdata) || (rdwen_w[k] !== req_we)) begin
          n_err++;
          $display("FAIL sram_drive dut%0d cyc %0d: got A=%h DI=%h RDWEN=%b want %h %h %b",
                   k, cyc, a_w[k], di_w[k], rdwen_w[k], req_addr, req_wdata, req_we);
        end
        n_vec++;
        if (bw_w[k] !== (req_we ? req_be : 4'b0000)) begin
          n_err++;
          $display("FAIL BW dut%0d cyc %0d: got %b want %b", k, cyc, bw_w[k],
                   req_we ? req_be : 4'b0000);
        end
        if (RST) begin
          sbq[k].delete();
        end else begin
          if (exp_val && rsp_ready) void'(sbq[k].pop_front());
          if (req_valid && exp_rdy) begin
            if (req_we) begin
              for (int b = 0; b < NC; b++) begin
                if (req_be[b]) ref_mem[k][req_addr][b*CW +: CW] = req_wdata[b*CW +: CW];
              end
            end else begin
              sbq[k].push_back('{data: ref_mem[k][req_addr], due: cyc + 2});
            end
          end
        end
      end
    end
  end

  task automatic drive(input logic rst, input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [NC-1:0] be, input logic rr);
    @(posedge CLK);
    #1;
    RST       = rst;
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    rsp_ready = rr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 4'h3, '0, '0, 1'b1);
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if ((req_ready_w[k] !== 1'b0) || (ce_w[k] !== 1'b0)) begin
        n_err++;
        $display("FAIL reset_read dut%0d: got ready=%b CE=%b want 0 0", k, req_ready_w[k],
                 ce_w[k]);
      end
    end
    drive(1'b1, 1'b1, 1'b1, 4'h3, 32'h1234, 4'hF, 1'b1);
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if ((req_ready_w[k] !== 1'b0) || (ce_w[k] !== 1'b0)) begin
        n_err++;
        $display("FAIL reset_write dut%0d: got ready=%b CE=%b want 0 0", k, req_ready_w[k],
                 ce_w[k]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    mon_en = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (rsp_valid_w[k] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_rsp_valid dut%0d: got %b want 0", k, rsp_valid_w[k]);
      end
    end
  endtask

  task automatic test_fill();
    for (int a = 0; a < 16; a++) drive(1'b0, 1'b1, 1'b1, AW'(a), $urandom, 4'hF, 1'b1);
    idle(1);
  endtask

  task automatic test_basic();
    drive(1'b0, 1'b1, 1'b1, 4'h5, 32'hAABBCCDD, 4'hF, 1'b1);
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if ((ce_w[k] !== 1'b1) || (rdwen_w[k] !== 1'b1)) begin
        n_err++;
        $display("FAIL basic_write_port dut%0d: got CE=%b RDWEN=%b want 1 1", k, ce_w[k],
                 rdwen_w[k]);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 4'h5, '0, 4'hF, 1'b1);
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if ((ce_w[k] !== 1'b1) || (rdwen_w[k] !== 1'b0) || (bw_w[k] !== 4'b0000)) begin
        n_err++;
        $display("FAIL basic_read_port dut%0d: got CE=%b RDWEN=%b BW=%b want 1 0 0000", k,
                 ce_w[k], rdwen_w[k], bw_w[k]);
      end
    end
    idle(1);
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (rsp_valid_w[k] !== 1'b0) begin
        n_err++;
        $display("FAIL basic_early_rsp dut%0d: got %b want 0", k, rsp_valid_w[k]);
      end
    end
    idle(1);
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if ((rsp_valid_w[k] !== 1'b1) || (rdata_w[k] !== 32'hAABBCCDD)) begin
        n_err++;
        $display("FAIL basic_rsp dut%0d: got valid=%b data=%h want 1 aabbccdd", k,
                 rsp_valid_w[k], rdata_w[k]);
      end
    end
    idle(2);
  endtask

  task automatic test_byte_write();
    drive(1'b0, 1'b1, 1'b1, 4'h5, 32'h00001100, 4'b0010, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 4'h5, '0, '0, 1'b1);
    idle(2);
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if ((rsp_valid_w[k] !== 1'b1) || (rdata_w[k] !== 32'hAABB11DD)) begin
        n_err++;
        $display("FAIL byte_write dut%0d: got valid=%b data=%h want 1 aabb11dd", k,
                 rsp_valid_w[k], rdata_w[k]);
      end
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 18; i++) begin
      if (i < 16) drive(1'b0, 1'b1, 1'b0, AW'(i), $urandom, 4'hF, 1'b1);
      else idle(1);
      @(negedge CLK);
      if (i < 16) begin
        n_vec++;
        if (req_ready_w[0] !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_ready step %0d: got %b want 1", i, req_ready_w[0]);
        end
      end
      if (i >= 2) begin
        n_vec++;
        if (rsp_valid_w[0] !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_rsp_valid step %0d: got %b want 1", i, rsp_valid_w[0]);
        end
      end
    end
    idle(4);
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, AW'($urandom), $urandom, NC'($urandom), 1'b0);
      @(negedge CLK);
      if (req_ready_w[0] === 1'b1) acc++;
    end
    n_vec++;
    if (acc !== 3) begin
      n_err++;
      $display("FAIL bp_read_accepts: got %0d want 3", acc);
    end
    drive(1'b0, 1'b1, 1'b1, AW'($urandom), $urandom, NC'($urandom), 1'b0);
    @(negedge CLK);
    n_vec++;
    if ((req_ready_w[0] !== 1'b1) || (ce_w[0] !== 1'b1)) begin
      n_err++;
      $display("FAIL bp_write_accept: got ready=%b CE=%b want 1 1", req_ready_w[0], ce_w[0]);
    end
    drive(1'b0, 1'b1, 1'b0, AW'($urandom), '0, '0, 1'b0);
    @(negedge CLK);
    n_vec++;
    if (req_ready_w[0] !== 1'b0) begin
      n_err++;
      $display("FAIL bp_read_blocked: got %b want 0", req_ready_w[0]);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1);
      @(negedge CLK);
      n_vec++;
      if (rsp_valid_w[0] !== (i < 3)) begin
        n_err++;
        $display("FAIL bp_drain step %0d: got %b want %b", i, rsp_valid_w[0], i < 3);
      end
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 1'b0, 4'h1, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'h2, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'h3, '0, '0, 1'b0);
    @(negedge CLK);
    n_vec++;
    if (req_ready_w[0] !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_third_read: got %b want 1", req_ready_w[0]);
    end
    drive(1'b1, 1'b1, 1'b0, 4'h4, '0, '0, 1'b0);
    @(negedge CLK);
    n_vec++;
    if ((ce_w[0] !== 1'b0) || (ce_w[1] !== 1'b0) || (rsp_valid_w[0] !== 1'b1)) begin
      n_err++;
      $display("FAIL rst_mid_during: got CE=%b/%b rsp_valid=%b want 0/0 1", ce_w[0], ce_w[1],
               rsp_valid_w[0]);
    end
    for (int i = 0; i < 5; i++) begin
      idle(1);
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (rsp_valid_w[k] !== 1'b0) begin
          n_err++;
          $display("FAIL rst_mid_stale dut%0d step %0d: got %b want 0", k, i, rsp_valid_w[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            AW'($urandom), $urandom, NC'($urandom), $urandom_range(0, 2) != 0);
    end
    idle(6);
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (rsp_valid_w[k] !== 1'b0) begin
        n_err++;
        $display("FAIL random_drain dut%0d: got %b want 0", k, rsp_valid_w[k]);
      end
    end
  endtask

  initial begin
    RST       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b1;
    mon_en    = 1'b0;
    cyc       = 0;
    n_vec     = 0;
    n_err     = 0;
    test_reset();
    test_fill();
    test_basic();
    test_byte_write();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    @(posedge CLK);
    #1;
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
